// File: rtl/core_biu_dmem_resp_pkg.sv
// Shared widths, access-size codes and FSM encodings for the data-memory BIU.
package core_biu_dmem_resp_pkg;

  localparam int CORE_XLEN   = 64;
  localparam int CORE_XBYTES = CORE_XLEN / 8;

  localparam logic [1:0] CORE_DMEM_SIZE_B = 2'd0;
  localparam logic [1:0] CORE_DMEM_SIZE_H = 2'd1;
  localparam logic [1:0] CORE_DMEM_SIZE_W = 2'd2;
  localparam logic [1:0] CORE_DMEM_SIZE_D = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic [CORE_XLEN-1:0]   addr;
    logic                   wen;
    logic [CORE_XLEN-1:0]   wdata;
    logic [CORE_XBYTES-1:0] wmask;
    logic [1:0]             size;
  } dmem_req_t;

  function automatic logic misaligned(
    input logic [2:0] lo,
    input logic [1:0] size
  );
    logic m;
    m = 1'b0;
    unique case (size)
      CORE_DMEM_SIZE_B: m = 1'b0;
      CORE_DMEM_SIZE_H: m = lo[0];
      CORE_DMEM_SIZE_W: m = |lo[1:0];
      CORE_DMEM_SIZE_D: m = |lo;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/core_biu_dmem_resp_sram.sv
// Single-port word array: byte-enabled synchronous write, combinational read.
module core_biu_sram
  import core_biu_dmem_resp_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          idx,
  input  logic [CORE_XBYTES-1:0] wmask,
  input  logic [CORE_XLEN-1:0]   wdata,
  output logic [CORE_XLEN-1:0]   rdata
);

  logic [CORE_XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < CORE_XBYTES; b++) begin
        if (wmask[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/core_biu_dmem_resp.sv
// Data-memory BIU: one outstanding access, fixed wait latency, range check.
// Define CORE_DMEM_MISALIGN_CHK_EN to flag accesses not aligned to their size.
module core_biu_dmem_resp
  import core_biu_dmem_resp_pkg::*;
#(
  parameter logic [CORE_XLEN-1:0] MEM_BASE    = 64'h8000_0000,
  parameter int                   MEM_DEPTH   = 1024,
  parameter int                   WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [CORE_XLEN-1:0]   req_addr,
  input  logic                   req_wen,
  input  logic [CORE_XLEN-1:0]   req_wdata,
  input  logic [CORE_XBYTES-1:0] req_wmask,
  input  logic [1:0]             req_size,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [CORE_XLEN-1:0]   rsp_rdata,
  output logic                   rsp_err
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int OB = $clog2(CORE_XBYTES);
  localparam logic [CORE_XLEN-1:0] SPAN =
    CORE_XLEN'(MEM_DEPTH) * CORE_XLEN'(CORE_XBYTES);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

`ifdef CORE_DMEM_MISALIGN_CHK_EN
  localparam logic MIS_CHK = 1'b1;
`else
  localparam logic MIS_CHK = 1'b0;
`endif

  logic [1:0]           state;
  logic [3:0]           cnt;
  dmem_req_t            req_q;
  logic [CORE_XLEN-1:0] off;
  logic                 in_range;
  logic                 mis;
  logic                 ok;
  logic                 enter_resp;
  logic                 commit;
  logic [CORE_XLEN-1:0] sram_rd;

  assign off        = req_q.addr - MEM_BASE;
  assign in_range   = (req_q.addr >= MEM_BASE) && (off < SPAN);
  assign mis        = MIS_CHK && misaligned(req_q.addr[2:0], req_q.size);
  assign ok         = in_range && !mis;
  assign enter_resp = (state == ST_WAIT) && (cnt == 4'd0);
  assign commit     = enter_resp && req_q.wen && ok;

  assign req_ready  = (state == ST_IDLE);
  assign rsp_valid  = (state == ST_RESP);

  core_biu_sram #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .we    (commit),
    .idx   (off[OB +: AW]),
    .wmask (req_q.wmask),
    .wdata (req_q.wdata),
    .rdata (sram_rd)
  );

  // Read data is captured on the same edge as the write, so writes
  // return the word as it was before the commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      req_q     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_q <= '{addr:  req_addr,
                       wen:   req_wen,
                       wdata: req_wdata,
                       wmask: req_wmask,
                       size:  req_size};
            cnt   <= WAIT_INIT;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= ST_RESP;
            rsp_rdata <= ok ? sram_rd : '0;
            rsp_err   <= !ok;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
